// File: rtl/present_pkg.sv
// Shared PRESENT definitions: FSM states, parameter legality checks,
// substitution and permutation layers (forward and inverse).
package present_pkg;

  typedef enum logic [2:0] {
    NO_KEY,
    EXPAND,
    IDLE,
    RUN,
    HOLD
  } core_state_t;

  // 4-bit S-box and its inverse as nibble lookup tables (entry 0 in the low nibble)
  localparam logic [63:0] SBOX_T     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX_T = 64'hA970364BD21C8FE5;

  function automatic bit key_width_ok(input int kw);
    return (kw == 80) || (kw == 128);
  endfunction

  function automatic bit rounds_ok(input int r);
    return (r >= 1) && (r <= 31);
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_T[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_T[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = sbox(x[4*n +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    return o;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays put
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[(i * 16) % 63] = x[i];
    o[63] = x[63];
    return o;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[i] = x[(i * 16) % 63];
    o[63] = x[63];
    return o;
  endfunction

endpackage

// File: rtl/present_key_step.sv
// One PRESENT key-schedule update: rotate left 61, S-box on the top
// nibble(s), XOR the round counter into the counter field.
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic [4:0]           rc,
  output logic [KEY_WIDTH-1:0] key_out
);

  logic [KEY_WIDTH-1:0] rot;

  // Combinational schedule step; 128-bit keys substitute two nibbles
  always_comb begin
    rot = {key_in[KEY_WIDTH-62:0], key_in[KEY_WIDTH-1:KEY_WIDTH-61]};
    key_out = rot;
    key_out[KEY_WIDTH-1 -: 4] = sbox(rot[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) begin
      key_out[KEY_WIDTH-5 -: 4] = sbox(rot[KEY_WIDTH-5 -: 4]);
      key_out[66:62] = rot[66:62] ^ rc;
    end else begin
      key_out[19:15] = rot[19:15] ^ rc;
    end
  end

endmodule

// File: rtl/present_core_param.sv
// Iterative PRESENT encrypt/decrypt engine with valid/ready key and block
// interfaces. Key expansion fills a round-key store once per key load;
// each block then takes one round per cycle plus one finishing cycle.
module present_core_param
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 enc_dec,
  input  logic [63:0]          block_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          block_o,
  output logic                 busy
);

  localparam int CW = $clog2(ROUNDS + 2);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS + 1);

  generate
    if (!key_width_ok(KEY_WIDTH)) begin : g_bad_key_width
      $error("present_core_param: KEY_WIDTH must be 80 or 128");
    end
    if (!rounds_ok(ROUNDS)) begin : g_bad_rounds
      $error("present_core_param: ROUNDS must be in 1..31");
    end
  endgenerate

  core_state_t          state_q, state_d;
  logic [CW-1:0]        kcnt;
  logic [CW-1:0]        rnd;
  logic                 mode;
  logic [KEY_WIDTH-1:0] keyreg;
  logic [KEY_WIDTH-1:0] key_next;
  logic [63:0]          rk [0:ROUNDS+1];
  logic [63:0]          blk;
  logic [63:0]          fwd_round;
  logic [63:0]          inv_round;
  logic [4:0]           rc5;
  logic                 key_fire;
  logic                 in_fire;
  logic                 run_done;

  // Handshake and status outputs decode directly from the state register.
  // A key offered in IDLE wins, so the block side is withheld that cycle.
  assign key_ready = (state_q == NO_KEY) || (state_q == IDLE);
  assign in_ready  = ((state_q == IDLE) && !key_valid) ||
                     ((state_q == HOLD) && out_ready);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == EXPAND) || (state_q == RUN);
  assign key_fire  = key_valid && key_ready;
  assign in_fire   = in_valid && in_ready;

  // Encrypt finishes once the counter has passed the last round; decrypt
  // finishes once it has counted down past round 1.
  assign run_done = (state_q == RUN) && (mode ? (rnd == '0) : (rnd == LAST));

  assign rc5       = 5'(kcnt);
  assign fwd_round = p_layer(s_layer(blk ^ rk[rnd]));
  assign inv_round = inv_s_layer(inv_p_layer(blk)) ^ rk[rnd];

  present_key_step #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_key_step (
    .key_in  (keyreg),
    .rc      (rc5),
    .key_out (key_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= NO_KEY;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      NO_KEY: if (key_valid) state_d = EXPAND;
      EXPAND: if (kcnt == LAST) state_d = IDLE;
      IDLE: begin
        if (key_valid)     state_d = EXPAND;
        else if (in_valid) state_d = RUN;
      end
      RUN:  if (run_done) state_d = HOLD;
      HOLD: if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = NO_KEY;
    endcase
  end

  // Control registers: counters, direction and the visible result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kcnt    <= '0;
      rnd     <= '0;
      mode    <= 1'b0;
      block_o <= '0;
    end else begin
      if (key_fire)                kcnt <= CW'(1);
      else if (state_q == EXPAND)  kcnt <= kcnt + 1'b1;

      if (in_fire) begin
        mode <= enc_dec;
        rnd  <= enc_dec ? CW'(ROUNDS) : CW'(1);
      end else if ((state_q == RUN) && !run_done) begin
        rnd  <= mode ? (rnd - 1'b1) : (rnd + 1'b1);
      end

      if (run_done) block_o <= mode ? blk : (blk ^ rk[LAST]);
    end
  end

  // Datapath registers: key register, round-key store and cipher state
  always_ff @(posedge clk) begin
    if (key_fire)               keyreg <= key;
    else if (state_q == EXPAND) keyreg <= key_next;

    if (state_q == EXPAND) rk[kcnt] <= keyreg[KEY_WIDTH-1 -: 64];

    if (in_fire)                            blk <= enc_dec ? (block_i ^ rk[LAST]) : block_i;
    else if ((state_q == RUN) && !run_done) blk <= mode ? inv_round : fwd_round;
  end

endmodule

// File: tb/tb_present_core_param.sv
// Bench for present_core_param: an 80-bit and a 128-bit instance driven
// with known-answer vectors, back-pressure, key/block priority and reset.
module tb_present_core_param;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         enc_dec   = 1'b0;
  logic [63:0]  block_i   = '0;
  logic         out_ready = 1'b1;

  logic         key_valid = 1'b0;
  logic [79:0]  key80     = '0;
  logic         in_valid  = 1'b0;
  logic         key_ready, in_ready, out_valid, busy;
  logic [63:0]  block_o;

  logic         w_key_valid = 1'b0;
  logic [127:0] key128      = '0;
  logic         w_in_valid  = 1'b0;
  logic         w_key_ready, w_in_ready, w_out_valid, w_busy;
  logic [63:0]  w_block_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  present_core_param #(.KEY_WIDTH(80), .ROUNDS(31)) dut80 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key80),
    .in_valid(in_valid), .in_ready(in_ready), .enc_dec(enc_dec), .block_i(block_i),
    .out_valid(out_valid), .out_ready(out_ready), .block_o(block_o), .busy(busy)
  );

  present_core_param #(.KEY_WIDTH(128), .ROUNDS(31)) dut128 (
    .clk(clk), .rst(rst), .key_valid(w_key_valid), .key_ready(w_key_ready), .key(key128),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .enc_dec(enc_dec), .block_i(block_i),
    .out_valid(w_out_valid), .out_ready(out_ready), .block_o(w_block_o), .busy(w_busy)
  );

  // ---------------- drivers (no checking) ----------------
  task automatic load_key80(input logic [79:0] k, output int nlow);
    int g;
    key_valid = 1'b1; key80 = k; #1;
    g = 0;
    while (!key_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    key_valid = 1'b0;
    nlow = 0;
    while (!key_ready && nlow < 200) begin nlow++; @(posedge clk); #1; end
  endtask

  task automatic load_key128(input logic [127:0] k, output int nlow);
    int g;
    w_key_valid = 1'b1; key128 = k; #1;
    g = 0;
    while (!w_key_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    w_key_valid = 1'b0;
    nlow = 0;
    while (!w_key_ready && nlow < 200) begin nlow++; @(posedge clk); #1; end
  endtask

  // Offers one block, records its expected result, and waits for out_valid.
  // enc_dec/block_i are scrambled after the accept edge.
  task automatic run80(input logic enc, input logic [63:0] blk, input logic [63:0] expv,
                       output int lat, output logic [63:0] got);
    int g;
    in_valid = 1'b1; enc_dec = enc; block_i = blk; #1;
    g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0; enc_dec = ~enc; block_i = ~blk;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
    if (!out_valid) lat = -1;
    got = block_o;
  endtask

  task automatic run128(input logic enc, input logic [63:0] blk, input logic [63:0] expv,
                        output int lat, output logic [63:0] got);
    int g;
    w_in_valid = 1'b1; enc_dec = enc; block_i = blk; #1;
    g = 0;
    while (!w_in_ready && g < 100) begin @(posedge clk); #1; g++; end
    exp_q.push_back(expv);
    @(posedge clk); #1;
    w_in_valid = 1'b0; enc_dec = ~enc; block_i = ~blk;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!w_out_valid && lat < 100);
    if (!w_out_valid) lat = -1;
    got = w_block_o;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (block_o !== 64'h0) begin bad++; $display("FAIL reset_block_o got=%h exp=0", block_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (w_key_ready !== 1'b1) begin bad++; $display("FAIL reset_w_key_ready got=%b exp=1", w_key_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_kat80_zero;
    int nlow, lat;
    logic [63:0] got, e;
    load_key80(80'h0, nlow);
    total++; if (nlow !== 32) begin bad++; $display("FAIL expand80_cycles got=%0d exp=32", nlow); end
    run80(1'b0, 64'h0, 64'h5579C1387B228445, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL kat80_zero got=%h exp=%h", got, e); end
    total++; if (lat !== 32) begin bad++; $display("FAIL kat80_zero_latency got=%0d exp=32", lat); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kat80_zero_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure;
    int lat;
    logic [63:0] got, e;
    out_ready = 1'b0;
    run80(1'b0, 64'h0, 64'h5579C1387B228445, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL bp_first got=%h exp=%h", got, e); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++; if (block_o !== e) begin bad++; $display("FAIL bp_hold_block cyc=%0d got=%h exp=%h", c, block_o, e); end
      total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold_flags cyc=%0d got=%b exp=10", c, {out_valid, in_ready}); end
    end
    out_ready = 1'b1; in_valid = 1'b1; enc_dec = 1'b0; block_i = 64'hFFFFFFFFFFFFFFFF;
    exp_q.push_back(64'hA112FFC72F68417B);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; block_i = 64'h0;
    total++; if ({out_valid, busy} !== 2'b01) begin bad++; $display("FAIL bp_consume_accept got=%b exp=01", {out_valid, busy}); end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
    e = exp_q.pop_front();
    total++; if (lat !== 32) begin bad++; $display("FAIL bp_second_latency got=%0d exp=32", lat); end
    total++; if (block_o !== e) begin bad++; $display("FAIL bp_second got=%h exp=%h", block_o, e); end
    consume();
  endtask

  task automatic test_key_priority;
    int n, lat;
    logic [63:0] e;
    key_valid = 1'b1; key80 = {80{1'b1}};
    in_valid = 1'b1; enc_dec = 1'b0; block_i = 64'h0;
    #1;
    total++; if ({key_ready, in_ready} !== 2'b10) begin bad++; $display("FAIL prio_ready got=%b exp=10", {key_ready, in_ready}); end
    @(posedge clk); #1;
    key_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin n++; @(posedge clk); #1; end
    total++; if (n !== 32) begin bad++; $display("FAIL prio_in_ready_low got=%0d exp=32", n); end
    exp_q.push_back(64'hE72C46C0F5945049);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
    e = exp_q.pop_front();
    total++; if (lat !== 32) begin bad++; $display("FAIL prio_latency got=%0d exp=32", lat); end
    total++; if (block_o !== e) begin bad++; $display("FAIL prio_new_key got=%h exp=%h", block_o, e); end
    consume();
  endtask

  task automatic test_kat80_ones;
    int lat;
    logic [63:0] got, e;
    run80(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL kat80_ones_enc got=%h exp=%h", got, e); end
    consume();
    run80(1'b1, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL kat80_ones_dec got=%h exp=%h", got, e); end
    total++; if (lat !== 32) begin bad++; $display("FAIL kat80_dec_latency got=%0d exp=32", lat); end
    consume();
  endtask

  task automatic test_kat128;
    int nlow, lat;
    logic [63:0] got, e;
    load_key128(128'h0, nlow);
    total++; if (nlow !== 32) begin bad++; $display("FAIL expand128_cycles got=%0d exp=32", nlow); end
    run128(1'b0, 64'h0, 64'h96DB702A2E6900AF, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL kat128_enc got=%h exp=%h", got, e); end
    total++; if (lat !== 32) begin bad++; $display("FAIL kat128_latency got=%0d exp=32", lat); end
    consume();
    run128(1'b1, 64'h96DB702A2E6900AF, 64'h0, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL kat128_dec got=%h exp=%h", got, e); end
    consume();
  endtask

  task automatic test_reset_mid_run;
    int g, n, nlow, lat;
    logic [63:0] got, e;
    in_valid = 1'b1; enc_dec = 1'b0; block_i = 64'h0123456789ABCDEF; #1;
    g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b0;
    #1;
    total++; if ({out_valid, key_ready, in_ready, busy} !== 4'b0100) begin
      bad++; $display("FAIL midrun_async_reset got=%b exp=0100", {out_valid, key_ready, in_ready, busy});
    end
    total++; if (block_o !== 64'h0) begin bad++; $display("FAIL midrun_block_o got=%h exp=0", block_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      #1; if (in_ready) n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (n !== 0) begin bad++; $display("FAIL midrun_no_key_in_ready got=%0d exp=0", n); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_no_output got=%b exp=0", out_valid); end
    load_key80(80'h0, nlow);
    run80(1'b0, 64'h0, 64'h5579C1387B228445, lat, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL midrun_reload got=%h exp=%h", got, e); end
    consume();
  endtask

  initial begin
    test_reset();
    test_kat80_zero();
    test_back_pressure();
    test_key_priority();
    test_kat80_ones();
    test_kat128();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/present_core_param.md
Name: present_core_param

Overview:
- Iterative PRESENT block cipher core with a parametrised key width (80 or 128 bits) and round count.
- Encrypt or decrypt is selected per block; key expansion runs once per key load into an internal round-key store.
- Key and data interfaces use valid/ready handshakes; the output holds under back-pressure.
- Successor to the fixed 80-bit, start-pulse PRESENT core; drop-in engine for the block_ciphers mode wrappers (ECB/CBC/CTR).

Parameters:
- KEY_WIDTH, 80, key length in bits; legal values 80 or 128 only; any other value fails elaboration.
- ROUNDS, 31, number of full rounds; legal range 1..31. Round-key store holds ROUNDS+1 entries of 64 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- key_valid  in  1  key offered
- key_ready  out  1  key accepted when key_valid && key_ready
- key  in  KEY_WIDTH  cipher key
- in_valid  in  1  block offered
- in_ready  out  1  block accepted when in_valid && in_ready
- enc_dec  in  1  0 = encrypt, 1 = decrypt; sampled with the block
- block_i  in  64  plaintext or ciphertext
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- block_o  out  64  result
- busy  out  1  high while key expansion or a block is in progress

Behaviour:
- Reset (rst=0, asynchronous): state NO_KEY; key_ready=1, in_ready=0, out_valid=0, block_o=0, busy=0. Round-key store contents are don't-care.
- States:
  - NO_KEY: key accepted -> EXPAND.
  - EXPAND: one round key per cycle.
  - IDLE: in_ready=1, key_ready=1.
  - RUN.
  - HOLD.
- EXPAND:
  - The key register loads the key. Write index i=1..ROUNDS+1 writes K_i = keyreg[KEY_WIDTH-1 -: 64].
  - Key register update per step:
    - Rotate left 61.
    - S-box on the top nibble (80-bit) or the top two nibbles (128-bit).
    - XOR the 5-bit round counter i into bits [19:15] (80-bit) or [66:62] (128-bit).
  - Exactly ROUNDS+1 cycles, then IDLE. key_ready=0 and in_ready=0 throughout.
- Encrypt:
  - On accept, state <= block_i, round r=1.
  - Each RUN cycle: state <= P(S(state ^ K_r)), r++.
  - After round ROUNDS: block_o <= state ^ K_{ROUNDS+1}, out_valid=1.
- Decrypt:
  - On accept, state <= block_i ^ K_{ROUNDS+1}, r=ROUNDS.
  - Each RUN cycle: state <= S^-1(P^-1(state)) ^ K_r, r--.
  - After r=1: block_o <= state.
- Latency: out_valid rises exactly ROUNDS+1 clock edges after the accepting edge (ROUNDS=31 -> 32).
- HOLD: out_valid and block_o stable until out_ready=1.
  - On the consume edge, out_valid falls and the state returns to IDLE.
  - in_ready is also 1 in HOLD when out_ready=1, giving back-to-back throughput of one block per ROUNDS+2 cycles.
- Key reload is allowed only in IDLE or NO_KEY. In IDLE, key_valid takes priority over in_valid on the same cycle: the key is accepted and the block is not.
- enc_dec and block_i are ignored outside the accept cycle. A mid-block change of enc_dec has no effect.
- Reset mid-operation: immediate return to the reset values. The previous key is invalidated and must be reloaded.
- The round counter is $clog2(ROUNDS+2) bits wide; the 5-bit XOR uses its low bits zero-extended.

Decomposition:
- Shared package present_pkg holds:
  - S-box and inverse S-box functions, and P-layer and inverse P-layer functions.
  - The state enum (NO_KEY, EXPAND, IDLE, RUN, HOLD).
  - KEY_WIDTH legal-value check.
- Sub-module present_key_step: combinational single key-schedule update, parametrised by KEY_WIDTH, taking key and counter.
- The round-key store is a register array. Read port indexed by r; write port by the expansion counter.

Test Plan:
- KEY_WIDTH=80, key=0, encrypt 0000000000000000 -> block_o=5579C1387B228445, out_valid 32 edges after accept.
- KEY_WIDTH=80, key=FFFFFFFFFFFFFFFFFFFF, encrypt FFFFFFFFFFFFFFFF -> 3333DCD3213210D2. Then decrypt 3333DCD3213210D2 with no key reload -> FFFFFFFFFFFFFFFF.
- KEY_WIDTH=128, key=0, encrypt 0 -> 96DB702A2E6900AF; decrypt it back -> 0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> block_o stable, in_ready=0. Release and offer the next block same cycle -> accepted on the consume edge.
- Simultaneous key_valid and in_valid in IDLE -> key accepted, in_ready=0 for 32 cycles (80-bit, ROUNDS=31). The subsequent encrypt of 0 under the new key FFFF..FF yields E72C46C0F5945049.
- Assert rst=0 asynchronously mid-RUN (round 10) -> out_valid=0 and key_ready=1 immediately. in_ready stays 0 until a key is reloaded.
